// File: rtl/fpdiv_ctrl.sv
// Start/done sequencer for the Goldschmidt fpdiv datapath: orders the NUM/DEN scaling,
// the ITA/ITB refinement pairs and the remainder capture. Optional FPDIV_CTRL_STALL_EN adds a stall input.
module fpdiv_ctrl #(
    parameter int NUM_ITER = 5,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef FPDIV_CTRL_STALL_EN
    input  logic             stall,
`endif
    output logic             busy,
    output logic             done,
    output logic [1:0]       sel_mux3,
    output logic [1:0]       sel_mux4,
    output logic             en_a,
    output logic             en_b,
    output logic             en_rem,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NUM  = 3'd1,
        S_DEN  = 3'd2,
        S_ITA  = 3'd3,
        S_ITB  = 3'd4,
        S_REM  = 3'd5,
        S_DONE = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ITER - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stallActive;
    logic             inBusyState;

`ifdef FPDIV_CTRL_STALL_EN
    assign stallActive = stall;
`else
    assign stallActive = 1'b0;
`endif

    assign inBusyState = (state_q == S_NUM) || (state_q == S_DEN) || (state_q == S_ITA) ||
                         (state_q == S_ITB) || (state_q == S_REM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_NUM;
            end
            S_NUM: state_d = S_DEN;
            S_DEN: begin
                state_d = S_ITA;
                count_d = '0;
            end
            S_ITA: state_d = S_ITB;
            S_ITB: begin
                if (count_q == LAST_CNT) begin
                    state_d = S_REM;
                end else begin
                    state_d = S_ITA;
                    count_d = count_q + 1'b1;
                end
            end
            S_REM: state_d = S_DONE;
            S_DONE: state_d = start ? S_NUM : S_IDLE;
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        // A stall freezes the whole sequence, including the iteration count.
        if (stallActive && inBusyState) begin
            state_d = state_q;
            count_d = count_q;
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        sel_mux3 = 2'b00;
        sel_mux4 = 2'b00;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_rem   = 1'b0;
        iter     = '0;
        case (state_q)
            S_NUM: begin
                busy = 1'b1;
                en_a = 1'b1;
            end
            S_DEN: begin
                busy     = 1'b1;
                sel_mux4 = 2'b01;
                en_b     = 1'b1;
            end
            S_ITA: begin
                busy     = 1'b1;
                sel_mux4 = 2'b10;
                sel_mux3 = 2'b01;
                en_a     = 1'b1;
                iter     = count_q;
            end
            S_ITB: begin
                busy     = 1'b1;
                sel_mux4 = 2'b11;
                sel_mux3 = 2'b01;
                en_b     = 1'b1;
                iter     = count_q;
            end
            S_REM: begin
                busy     = 1'b1;
                sel_mux4 = 2'b10;
                sel_mux3 = 2'b10;
                en_rem   = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
        // Selects stay put during a stall so only the register loads are suppressed.
        if (stallActive) begin
            en_a   = 1'b0;
            en_b   = 1'b0;
            en_rem = 1'b0;
        end
    end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Self-checking bench for fpdiv_ctrl: position-in-operation reference model compared every cycle,
// directed scenarios with literal expectations, then randomized start/reset (and stall when FPDIV_CTRL_STALL_EN).
module tb_fpdiv_ctrl;
    localparam int NUM_ITER = 5;
    localparam int CNT_W    = 4;
    localparam int OP_LEN   = 2 * NUM_ITER + 4;
    localparam int OW       = 9 + CNT_W;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             busy, done, en_a, en_b, en_rem;
    logic [1:0]       sel_mux3, sel_mux4;
    logic [CNT_W-1:0] iter;
    bit               stallNow;
`ifdef FPDIV_CTRL_STALL_EN
    logic             stall = 1'b0;
    assign stallNow = stall;
`else
    assign stallNow = 1'b0;
`endif

    fpdiv_ctrl #(.NUM_ITER(NUM_ITER), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef FPDIV_CTRL_STALL_EN
        .stall    (stall),
`endif
        .busy     (busy),
        .done     (done),
        .sel_mux3 (sel_mux3),
        .sel_mux4 (sel_mux4),
        .en_a     (en_a),
        .en_b     (en_b),
        .en_rem   (en_rem),
        .iter     (iter)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;
    // Reference position: 0 = idle, 1 = first cycle of an operation ... OP_LEN = done cycle.
    int pos         = 0;

    always @(posedge clk) begin
        if (!reset)
            pos <= 0;
        else if (pos == 0 || pos == OP_LEN)
            pos <= start ? 1 : 0;
        else if (!stallNow)
            pos <= pos + 1;
    end

    function automatic logic [OW-1:0] expectOut(input int p, input bit st);
        logic             eBusy, eDone, eA, eB, eRem;
        logic [1:0]       eM3, eM4;
        logic [CNT_W-1:0] eIter;
        int               k;
        eBusy = 0; eDone = 0; eA = 0; eB = 0; eRem = 0; eM3 = 0; eM4 = 0; eIter = 0;
        if (p >= 1 && p <= OP_LEN - 1) eBusy = 1;
        if (p == 1) begin
            eA = 1;
        end else if (p == 2) begin
            eM4 = 2'd1; eB = 1;
        end else if (p >= 3 && p <= OP_LEN - 2) begin
            k     = p - 3;
            eM3   = 2'd1;
            eIter = CNT_W'(k / 2);
            if (k % 2 == 0) begin eM4 = 2'd2; eA = 1; end
            else            begin eM4 = 2'd3; eB = 1; end
        end else if (p == OP_LEN - 1) begin
            eM4 = 2'd2; eM3 = 2'd2; eRem = 1;
        end else if (p == OP_LEN) begin
            eDone = 1;
        end
        if (st) begin eA = 0; eB = 0; eRem = 0; end
        return {eBusy, eDone, eM3, eM4, eA, eB, eRem, eIter};
    endfunction

    always @(negedge clk) begin
        logic [OW-1:0] act, exp;
        if (checkEn) begin
            act = {busy, done, sel_mux3, sel_mux4, en_a, en_b, en_rem, iter};
            exp = expectOut(pos, stallNow);
            testsRun++;
            if (act !== exp) begin
                testsFailed++;
                $display("[TB] FAIL cycle_outputs t=%0t pos=%0d actual=%h expected=%h", $time, pos, act, exp);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    int expMux4 [14] = '{0, 1, 2, 3, 2, 3, 2, 3, 2, 3, 2, 3, 2, 0};
    int expMux3 [14] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 0};
    int expIter [14] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};

    initial begin
        int doneCnt, doneAt, busyCnt, enCnt;
        int doneCycles[$];

        // Reset then idle
        reset = 0;
        repeat (3) applyStimulus();
        checkEn = 1;
        @(negedge clk);
        checkOutput("reset_outputs", int'({busy, done, sel_mux3, sel_mux4, en_a, en_b, en_rem, iter}), 0);
        reset = 1;
        repeat (10) applyStimulus();
        checkOutput("idle_outputs", int'({busy, done, sel_mux3, sel_mux4, en_a, en_b, en_rem, iter}), 0);

        // Single operation with literal sequence checks
        start = 1; applyStimulus(); start = 0;
        doneCnt = 0; doneAt = 0; enCnt = 0;
        for (int c = 1; c <= OP_LEN; c++) begin
            @(negedge clk);
            checkOutput($sformatf("mux4_c%0d", c), int'(sel_mux4), expMux4[c-1]);
            checkOutput($sformatf("mux3_c%0d", c), int'(sel_mux3), expMux3[c-1]);
            checkOutput($sformatf("iter_c%0d", c), int'(iter), expIter[c-1]);
            enCnt += int'(en_a) + int'(en_b) + int'(en_rem);
            if (done) begin doneCnt++; doneAt = c; end
            applyStimulus();
        end
        checkOutput("single_done_count", doneCnt, 1);
        checkOutput("single_done_cycle", doneAt, 14);
        checkOutput("single_enable_total", enCnt, 13);

        // Start pulses while busy are ignored
        start = 1; applyStimulus(); start = 0;
        doneCnt = 0; doneAt = 0; busyCnt = 0;
        for (int c = 1; c <= 20; c++) begin
            start = (c == 3 || c == 9);
            @(negedge clk);
            if (done) begin doneCnt++; doneAt = c; end
            busyCnt += int'(busy);
            applyStimulus();
        end
        start = 0;
        checkOutput("busy_start_done_count", doneCnt, 1);
        checkOutput("busy_start_done_cycle", doneAt, 14);
        checkOutput("busy_start_busy_cycles", busyCnt, 13);
        repeat (3) applyStimulus();

        // Back-to-back with start held high
        start = 1;
        doneCycles.delete();
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done) doneCycles.push_back(c);
            applyStimulus();
        end
        start = 0;
        checkOutput("b2b_done_count", doneCycles.size(), 3);
        if (doneCycles.size() == 3) begin
            checkOutput("b2b_first_done", doneCycles[0], 14);
            checkOutput("b2b_period_1", doneCycles[1] - doneCycles[0], 14);
            checkOutput("b2b_period_2", doneCycles[2] - doneCycles[1], 14);
        end
        repeat (16) applyStimulus();

        // Reset during the third ITB
        start = 1; applyStimulus(); start = 0;
        repeat (7) applyStimulus();
        @(negedge clk);
        checkOutput("midop_in_itb_mux4", int'(sel_mux4), 3);
        checkOutput("midop_in_itb_iter", int'(iter), 2);
        reset = 0; applyStimulus(); reset = 1;
        @(negedge clk);
        checkOutput("midop_reset_outputs", int'({busy, done, sel_mux3, sel_mux4, en_a, en_b, en_rem, iter}), 0);
        applyStimulus();
        start = 1; applyStimulus(); start = 0;
        doneAt = 0;
        for (int c = 1; c <= OP_LEN; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput("after_reset_num_en_a", int'(en_a), 1);
            if (done) doneAt = c;
            applyStimulus();
        end
        checkOutput("after_reset_done_cycle", doneAt, 14);

`ifdef FPDIV_CTRL_STALL_EN
        // Stall three cycles in ITA with iter=2
        start = 1; applyStimulus(); start = 0;
        repeat (6) applyStimulus();
        stall = 1;
        for (int c = 7; c <= 9; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_en_a_c%0d", c), int'(en_a), 0);
            checkOutput($sformatf("stall_mux4_c%0d", c), int'(sel_mux4), 2);
            checkOutput($sformatf("stall_busy_c%0d", c), int'(busy), 1);
            applyStimulus();
        end
        stall = 0;
        doneAt = 0;
        for (int c = 10; c <= 20; c++) begin
            @(negedge clk);
            if (c == 10) checkOutput("stall_resume_en_a", int'(en_a), 1);
            if (done) doneAt = c;
            applyStimulus();
        end
        checkOutput("stall_done_cycle", doneAt, 17);
`endif

        // Randomized traffic checked by the reference model
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 149) != 0);
`ifdef FPDIV_CTRL_STALL_EN
            stall = ($urandom_range(0, 4) == 0);
`endif
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
- Sequencing controller for the Goldschmidt `fpdiv` datapath. It sits directly upstream of `fpdiv` and drives the datapath's `sel_mux3`, `sel_mux4`, `en_a`, `en_b` and `en_rem` controls.
- It replaces hand-timed stimulus with a start/done handshake. Operand registers and the result path stay inside `fpdiv`; this block only orders the multiply/capture cycles.

Parameters:
- NUM_ITER, 5, number of refinement iteration pairs after the initial numerator/denominator scaling; legal range 1..15.
- CNT_W, 4, width of the iteration counter; must satisfy 2^CNT_W > NUM_ITER.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  request a new divide; sampled only in IDLE or DONE
- busy  output  1  high from the NUM cycle through the REM cycle inclusive
- done  output  1  one-cycle pulse; the `fpdiv` result is valid this cycle
- sel_mux3  output  2  00 = multiplicand from IA; 01 = from C register; 10 = remainder path
- sel_mux4  output  2  00 = numerator; 01 = denominator; 10 = A feedback; 11 = B feedback
- en_a  output  1  load enable for the A (quotient) register
- en_b  output  1  load enable for the B (divisor) register
- en_rem  output  1  load enable for the remainder register
- iter  output  CNT_W  current iteration index (0 outside ITA/ITB); debug only

Behaviour:
- Reset: clock `clk`; reset `reset` is synchronous, active-low.
  - While reset=0 at a rising edge: state←IDLE, iteration counter←0.
  - All outputs are then 0: busy, done, en_a, en_b, en_rem, sel_mux3=00, sel_mux4=00, iter=0.
- Reset mid-operation behaves identically. No partial sequence resumes after reset.
- Moore FSM with outputs decoded from the state register only. No output depends combinationally on start.
- States and per-state outputs (any signal not listed is 0/00):
  - IDLE: all outputs 0.
  - NUM: sel_mux4=00, sel_mux3=00, en_a=1, busy=1.
  - DEN: sel_mux4=01, sel_mux3=00, en_b=1, busy=1.
  - ITA: sel_mux4=10, sel_mux3=01, en_a=1, busy=1, iter=count.
  - ITB: sel_mux4=11, sel_mux3=01, en_b=1, busy=1, iter=count.
  - REM: sel_mux4=10, sel_mux3=10, en_rem=1, busy=1.
  - DONE: done=1, all other outputs 0.
- Transitions (evaluated at each rising edge with reset=1):
  - IDLE: start=1 → NUM; otherwise stay in IDLE.
  - NUM → DEN unconditionally.
  - DEN → ITA, with count←0.
  - ITA → ITB.
  - ITB: if count==NUM_ITER-1 → REM, otherwise → ITA with count←count+1.
  - REM → DONE.
  - DONE: start=1 → NUM (back-to-back operation, no idle bubble); otherwise → IDLE.
- Latency: start sampled at edge k → NUM is active in cycle k+1 → done is high in cycle k+2+2·NUM_ITER+2. With NUM_ITER=5, done is 14 cycles after the start edge.
- Exactly one of en_a/en_b/en_rem is high in every busy cycle. None is high in IDLE or DONE.
- start is ignored while busy=1; no queuing. Holding start high continuously gives back-to-back divides with period 2·NUM_ITER+4 cycles.
- The counter does not wrap. It is cleared on DEN entry and on reset, and reads 0 in all states other than ITA/ITB.
- Illegal or unused state encodings → IDLE on the next edge, with outputs 0 while in them.

Optional Feature:
- Macro FPDIV_CTRL_STALL_EN.
- Defined:
  - Adds input `stall` (1 bit).
  - While stall=1 in NUM/DEN/ITA/ITB/REM, state and count hold. All enables are forced to 0 but sel values are held, so no datapath register updates.
  - Sequencing resumes on the first edge with stall=0.
  - stall has no effect in IDLE or DONE.
  - Reset overrides stall.
  - busy stays 1 during a stall.
- Not defined: no `stall` port; the sequence is fixed-length as described above.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, then release with start=0 for 10 cycles → all outputs stay 0 and iter=0.
- Single op, NUM_ITER=5: start pulse for 1 cycle →
  - sel_mux4 sequence 00,01,(10,11)x5,10.
  - sel_mux3 sequence 00,00,01 x10,10.
  - en_a/en_b/en_rem one-hot for 13 cycles.
  - done=1 for exactly 1 cycle, 14 cycles after the start edge.
  - iter counts 0..4.
- Start while busy: pulse start again in cycles 3 and 9 of an operation → no effect; one done only; busy waveform identical to the single-op case.
- Back-to-back: hold start=1 continuously → done pulses every 14 cycles and NUM immediately follows DONE.
- Reset mid-op: drive reset=0 during the 3rd ITB → next cycle all outputs 0; a new start afterwards runs the full sequence from NUM.
- Stall (with FPDIV_CTRL_STALL_EN): assert stall for 3 cycles during ITA, iter=2 →
  - en_a=0 and sel_mux4 held at 10 for those 3 cycles.
  - Sequence then resumes at ITA; done arrives 17 cycles after the start edge.
